mux_rr_4x1: RTL and testbench
=============================

Name: mux_rr_4x1

Overview:
- 4-to-1 collecting multiplexer; the inverse of the team's 1-to-4 demux.
- Gathers words from four source channels and emits them one at a time on a single output.
- Tags each output word with the 2-bit source index S, so a downstream demux can route it back to the correct Y line.
- Round-robin arbitration with per-channel valid/ready handshake; one registered output stage.

Parameters:
- W, 1, data width per channel in bits.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- D  input  4*W  channel data, packed; channel n occupies D[n*W +: W].
- V  input  4  per-channel valid; V[n]=1 means D for channel n holds a word.
- R  output  4  per-channel ready/accept (combinational); at most one bit high per cycle.
- Y  output  W  registered output word.
- S  output  2  registered source index of Y (00 to 11); same encoding as the demux select.
- YV  output  1  output valid.
- YR  input  1  downstream ready.

Behaviour:
- Reset (RST=1 at a clock edge):
  - Y=0, S=2'b00, YV=0.
  - Round-robin pointer LAST=2'b11, so the first search starts at channel 0.
  - R=4'b0000 in every cycle while RST=1, regardless of V.
- Transfer rules:
  - A source transfer occurs on a cycle where V[n]=1 and R[n]=1.
  - An output transfer occurs on a cycle where YV=1 and YR=1.
- State machine, two states:
  - EMPTY (YV=0) and FULL (YV=1). The state is YV itself.
- Load condition:
  - LOAD = (YV==0) or (YR==1), i.e. the stage is empty or is draining this cycle.
- Arbitration, evaluated combinationally each cycle when LOAD=1:
  - Search order is LAST+1, LAST+2, LAST+3, LAST (mod 4).
  - The first channel with V=1 is granted: R[g]=1 and all other R bits are 0.
  - When LOAD=0, R=4'b0000.
- On the clock edge with a grant g:
  - Y <= D[g*W +: W], S <= g, YV <= 1, LAST <= g.
- On the clock edge with LOAD=1 and no V bit set:
  - YV <= 0; Y and S hold their last values; LAST holds.
- FULL and YR=0:
  - Y, S, YV, LAST all hold; no R asserted.
  - Source V/D may change freely; a source is not accepted until its R is high.
- Simultaneous drain and load (FULL, YR=1, some V set):
  - The new word is loaded in the same edge; YV stays 1.
  - Sustained throughput is 1 word/cycle.
- Latency: a word accepted at edge k appears on Y/S/YV after edge k, i.e. 1 cycle.
- Fairness: with all four V held high and YR=1, the grant sequence is 0,1,2,3,0,... A requesting channel waits at most 3 grants.
- Wrap-around: LAST=3 -> next search starts at 0. Natural 2-bit overflow; no special case.
- Reset mid-operation: a pending FULL word is discarded, YV=0 on the next cycle, and the pointer returns to LAST=3.
- Outputs Y and S are meaningful only while YV=1.

Optional Feature:
- Macro: MUX_RR_FIXED_PRIORITY_EN.
- Defined:
  - Arbitration is fixed priority; channel 0 is highest, channel 3 lowest.
  - Search order is always 0,1,2,3.
  - LAST is not implemented; fairness is not guaranteed.
- Not defined:
  - Round-robin as specified above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan (W=4):
- Reset then idle:
  - Stimulus: RST=1 for 2 cycles, V=0000.
  - Required: Y=0, S=00, YV=0, R=0000 throughout, including cycles where V=1111 while RST=1.
- Single channel:
  - Stimulus: after reset, V=0100, D[11:8]=4'hA, YR=1.
  - Required: R=0100 in that cycle; next cycle Y=4'hA, S=10, YV=1.
- Round-robin:
  - Stimulus: V=1111, D = 4'h3,4'h2,4'h1,4'h0 for channels 3..0, YR=1 for 6 cycles.
  - Required: S sequence 00,01,10,11,00,01 with matching Y.
  - With MUX_RR_FIXED_PRIORITY_EN defined: S=00 every cycle.
- Backpressure:
  - Stimulus: FULL with S=01, Y=4'h5; YR=0 for 3 cycles while V=1001.
  - Required: R=0000, Y/S/YV hold.
  - Then YR=1: R=1000 and next cycle S=11 (search starts after 01).
- Drain to empty:
  - Stimulus: FULL, YR=1, V=0000.
  - Required: next cycle YV=0, S and Y unchanged.
- Reset mid-operation:
  - Stimulus: FULL with S=10, RST=1 for one cycle with V=1111.
  - Required: YV=0 after the edge; first grant after reset release is channel 0.

Source files
------------

// File: rtl/mux_rr_4x1.sv
// 4-to-1 collecting multiplexer with a per-channel valid/ready handshake and one registered output stage.
// Round-robin arbitration by default; define MUX_RR_FIXED_PRIORITY_EN for fixed priority (channel 0 highest).
module mux_rr_4x1 #(
  parameter int W = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [4*W-1:0] D,
  input  logic [3:0]     V,
  output logic [3:0]     R,
  output logic [W-1:0]   Y,
  output logic [1:0]     S,
  output logic           YV,
  input  logic           YR
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_s;
  logic         load_s;
  logic         found_s;
  logic [1:0]   grant_s;
  logic [1:0]   start_s;
  logic [W-1:0] data_s;

`ifndef MUX_RR_FIXED_PRIORITY_EN
  logic [1:0]   last_r;
`endif

  // First requesting channel scanning start, start+1, ... (mod 4); result is {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!res[2] && req[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Search origin: just past the last grant, or always channel 0 in the fixed-priority build.
  always_comb begin
`ifdef MUX_RR_FIXED_PRIORITY_EN
    start_s = 2'b00;
`else
    start_s = last_r + 2'b01;
`endif
  end

  // Grant selection, handshake ready and next-state decode.
  always_comb begin
    {found_s, grant_s} = pick(V, start_s);
    load_s = (state_r == EMPTY) || YR;
    if (!RST && load_s && found_s) begin
      R = 4'b0001 << grant_s;
    end else begin
      R = 4'b0000;
    end
    if (load_s) begin
      state_s = found_s ? FULL : EMPTY;
    end else begin
      state_s = state_r;
    end
  end

  // Data path mux for the granted channel.
  always_comb begin
    data_s = '0;
    for (int n = 0; n < 4; n++) begin
      if (grant_s == 2'(n)) begin
        data_s = D[n*W +: W];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Output stage and arbitration pointer; Y/S only move on a grant, so they hold through a drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= EMPTY;
      Y       <= '0;
      S       <= 2'b00;
`ifndef MUX_RR_FIXED_PRIORITY_EN
      last_r  <= 2'b11;
`endif
    end else begin
      state_r <= state_s;
      if (load_s && found_s) begin
        Y      <= data_s;
        S      <= grant_s;
`ifndef MUX_RR_FIXED_PRIORITY_EN
        last_r <= grant_s;
`endif
      end
    end
  end

  assign YV = (state_r == FULL);

endmodule

// File: tb/tb_mux_rr_4x1.sv
// Directed bench for mux_rr_4x1 (W=4) with a scoreboard of granted words and an output-stage model.
module tb_mux_rr_4x1;

  localparam int W = 4;

  logic          CLK;
  logic          RST;
  logic [4*W-1:0] D;
  logic [3:0]    V;
  logic [3:0]    R;
  logic [W-1:0]  Y;
  logic [1:0]    S;
  logic          YV;
  logic          YR;

  int checks;
  int errors;

  logic [5:0]   sb_q[$];
  logic [W-1:0] exp_y;
  logic [1:0]   exp_s;
  logic         exp_yv;

  mux_rr_4x1 #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .D(D), .V(V), .R(R),
    .Y(Y), .S(S), .YV(YV), .YR(YR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check R before the rising edge, check outputs after it.
  task automatic step(input string tag, input logic rst, input logic [3:0] v,
                      input logic [15:0] d, input logic yr, input logic [3:0] exp_r);
    logic       granted;
    logic [1:0] g;
    logic [5:0] item;
    RST = rst; V = v; D = d; YR = yr;
    #1;
    check({tag, ".R"}, {12'h000, R}, {12'h000, exp_r});
    granted = 1'b0;
    g = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (exp_r[i]) begin
        granted = 1'b1;
        g = 2'(i);
      end
    end
    if (granted) begin
      sb_q.push_back({g, d[g*W +: W]});
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      exp_y = '0; exp_s = 2'b00; exp_yv = 1'b0;
    end else if (granted) begin
      item = sb_q.pop_front();
      exp_s = item[5:4]; exp_y = item[3:0]; exp_yv = 1'b1;
    end else if (!exp_yv || yr) begin
      exp_yv = 1'b0;
    end
    check({tag, ".YV"}, {15'h0000, YV}, {15'h0000, exp_yv});
    check({tag, ".S"}, {14'h0000, S}, {14'h0000, exp_s});
    check({tag, ".Y"}, {12'h000, Y}, {12'h000, exp_y});
    @(negedge CLK);
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_y = '0; exp_s = 2'b00; exp_yv = 1'b0;
    RST = 1'b1; V = 4'b0000; D = 16'h0000; YR = 1'b0;
    @(negedge CLK);

    // Reset and idle, including requests held while reset is high
    step("rst0", 1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000);
    step("rst1", 1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000);
    step("rstv", 1'b1, 4'b1111, 16'h3210, 1'b1, 4'b0000);
    step("idle", 1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000);

    // Single channel
    step("single", 1'b0, 4'b0100, 16'h0A00, 1'b1, 4'b0100);

    // All channels requesting, starting from a fresh pointer
    step("rst2", 1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000);
`ifdef MUX_RR_FIXED_PRIORITY_EN
    for (int k = 0; k < 6; k++) step("rr", 1'b0, 4'b1111, 16'h3210, 1'b1, 4'b0001);
`else
    step("rr0", 1'b0, 4'b1111, 16'h3210, 1'b1, 4'b0001);
    step("rr1", 1'b0, 4'b1111, 16'h3210, 1'b1, 4'b0010);
    step("rr2", 1'b0, 4'b1111, 16'h3210, 1'b1, 4'b0100);
    step("rr3", 1'b0, 4'b1111, 16'h3210, 1'b1, 4'b1000);
    step("rr4", 1'b0, 4'b1111, 16'h3210, 1'b1, 4'b0001);
    step("rr5", 1'b0, 4'b1111, 16'h3210, 1'b1, 4'b0010);
`endif

    // Backpressure: load S=01/Y=5, stall three cycles, then release
    step("bp_load", 1'b0, 4'b0010, 16'h0050, 1'b1, 4'b0010);
    step("bp_hold0", 1'b0, 4'b1001, 16'h9008, 1'b0, 4'b0000);
    step("bp_hold1", 1'b0, 4'b1001, 16'h9008, 1'b0, 4'b0000);
    step("bp_hold2", 1'b0, 4'b1001, 16'h9008, 1'b0, 4'b0000);
`ifdef MUX_RR_FIXED_PRIORITY_EN
    step("bp_rel", 1'b0, 4'b1001, 16'h9008, 1'b1, 4'b0001);
`else
    step("bp_rel", 1'b0, 4'b1001, 16'h9008, 1'b1, 4'b1000);
`endif

    // Drain to empty, then idle with downstream stalled
    step("drain", 1'b0, 4'b0000, 16'hFFFF, 1'b1, 4'b0000);
    step("empty_stall", 1'b0, 4'b0000, 16'hFFFF, 1'b0, 4'b0000);
    step("empty_load", 1'b0, 4'b0001, 16'h000C, 1'b0, 4'b0001);

    // Reset mid-operation with a FULL word from channel 2 pending
    step("mid_load", 1'b0, 4'b0100, 16'h0700, 1'b1, 4'b0100);
    step("mid_rst", 1'b1, 4'b1111, 16'h4321, 1'b1, 4'b0000);
    step("mid_first", 1'b0, 4'b1111, 16'h4321, 1'b1, 4'b0001);
    step("mid_drain", 1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000);

    check("sb_empty", 16'(sb_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
